interrupt_ack_sequencer: RTL and testbench

Downstream consumer of the priority resolver in the 8259A PIC. It turns a resolved request (INT_request plus serviced_interrupt_index) into the CPU INT line, walks the INTA pulse sequence, and freezes the resolver while the sequence runs. It pulses the ISR set (and AEOI clear) strobes and drives the vector or CALL bytes onto the internal data bus. It supports 8086 mode (2 INTA pulses) and 8080/85 mode (3 INTA pulses).

---
 rtl/interrupt_ack_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_ack_sequencer
//
// Purpose:
//   Sits behind the 8259A priority resolver. It turns a resolved request into
//   the CPU INT line and walks the INTA pulse sequence:
//     - 8086 mode:    two pulses, the second returns the vector byte.
//     - 8080/85 mode: three pulses returning CALL (CD), the low address byte
//                     and the high address byte.
//   While the sequence runs, it freezes the resolver. It also pulses the
//   ISR set strobe at the first INTA fall, and the AEOI clear strobe at the
//   final INTA rise.
//
// Ports:
//   clk                       system clock, rising edge
//   rst_n                     synchronous active-low reset
//   INT_request               resolver has a request above in-service levels
//   serviced_interrupt_index  resolver's winning IR index
//   INTA_n                    CPU acknowledge, active low, synchronised to clk
//   mode_8086                 1 = 8086 (2 pulses), 0 = 8080/85 (3 pulses)
//   aeoi                      automatic end-of-interrupt enable
//   icw2                      vector base (8086) / CALL high byte (8080)
//   icw1_addr                 8080 call address bits A7-A5
//   adi                       8080 call address interval: 1 = 4, 0 = 8
//   INT                       interrupt request to the CPU
//   INT_requestAck            toggles once per acknowledged (non-spurious) request
//   freezing                  holds the resolver outputs while high
//   isr_set                   one-hot, one-cycle ISR set strobe
//   aeoi_clr                  one-hot, one-cycle ISR clear strobe (AEOI only)
//   data_out                  byte for the data bus buffer
//   data_oe                   data_out valid / bus drive enable
// -----------------------------------------------------------------------------
module interrupt_ack_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT_request,
    input  logic [2:0] serviced_interrupt_index,
    input  logic       INTA_n,
    input  logic       mode_8086,
    input  logic       aeoi,
    input  logic [7:0] icw2,
    input  logic [2:0] icw1_addr,
    input  logic       adi,
    output logic       INT,
    output logic       INT_requestAck,
    output logic       freezing,
    output logic [7:0] isr_set,
    output logic [7:0] aeoi_clr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK1 = 2'd1,
        S_ACK2 = 2'd2,
        S_ACK3 = 2'd3
    } state_t;

    state_t     state_q;
    logic       inta_q;
    logic [2:0] idx_q;
    logic       spurious_q;
    logic       int_q;
    logic       ack_q;
    logic       freezing_q;
    logic [7:0] isr_set_q;
    logic [7:0] aeoi_clr_q;
    logic [7:0] data_out_q;
    logic       data_oe_q;

    logic       fall_s;
    logic       rise_s;

    // One-hot decode of a 3-bit IR index.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // 8086 vector: the upper five bits come from ICW2, the low three bits
    // are the IR index.
    function automatic logic [7:0] vector_8086(input logic [7:0] base,
                                               input logic [2:0] idx);
        return {base[7:3], idx};
    endfunction

    // 8080 CALL low address byte. With interval 4, all of A7-A5 come from
    // ICW1. With interval 8, the IR index pushes up into A5, so only A7-A6
    // are taken from ICW1.
    function automatic logic [7:0] call_low_8080(input logic [2:0] addr,
                                                 input logic [2:0] idx,
                                                 input logic       adi_i);
        logic [7:0] r;
        if (adi_i) begin
            r = {addr, idx, 2'b00};
        end else begin
            r = {addr[2:1], idx, 3'b000};
        end
        return r;
    endfunction

    // INTA edge detection against the previous sampled level.
    assign fall_s = inta_q & ~INTA_n;
    assign rise_s = ~inta_q & INTA_n;

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            inta_q     <= 1'b1;
            idx_q      <= 3'd0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            ack_q      <= 1'b0;
            freezing_q <= 1'b0;
            isr_set_q  <= 8'h00;
            aeoi_clr_q <= 8'h00;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
        end else begin
            inta_q     <= INTA_n;
            // Both strobes are single-cycle pulses.
            isr_set_q  <= 8'h00;
            aeoi_clr_q <= 8'h00;

            case (state_q)
                S_IDLE: begin
                    if (fall_s) begin
                        freezing_q <= 1'b1;
                        int_q      <= 1'b0;
                        state_q    <= S_ACK1;
                        if (INT_request) begin
                            idx_q      <= serviced_interrupt_index;
                            spurious_q <= 1'b0;
                            isr_set_q  <= onehot8(serviced_interrupt_index);
                            ack_q      <= ~ack_q;
                        end else begin
                            // The request vanished before INTA: report IR7
                            // without touching the ISR.
                            idx_q      <= 3'd7;
                            spurious_q <= 1'b1;
                        end
                        if (!mode_8086) begin
                            data_out_q <= 8'hCD;
                            data_oe_q  <= 1'b1;
                        end else begin
                            data_oe_q  <= 1'b0;
                        end
                    end else begin
                        int_q <= INT_request;
                    end
                end

                S_ACK1: begin
                    if (rise_s) begin
                        data_oe_q <= 1'b0;
                    end else if (fall_s) begin
                        data_oe_q <= 1'b1;
                        state_q   <= S_ACK2;
                        if (mode_8086) begin
                            data_out_q <= vector_8086(icw2, idx_q);
                        end else begin
                            data_out_q <= call_low_8080(icw1_addr, idx_q, adi);
                        end
                    end else begin
                        state_q <= S_ACK1;
                    end
                end

                S_ACK2: begin
                    if (rise_s) begin
                        data_oe_q <= 1'b0;
                        if (mode_8086) begin
                            // Last pulse of the 8086 sequence.
                            freezing_q <= 1'b0;
                            state_q    <= S_IDLE;
                            if (aeoi && !spurious_q) begin
                                aeoi_clr_q <= onehot8(idx_q);
                            end else begin
                                aeoi_clr_q <= 8'h00;
                            end
                        end else begin
                            state_q <= S_ACK2;
                        end
                    end else if (fall_s && !mode_8086) begin
                        data_out_q <= icw2;
                        data_oe_q  <= 1'b1;
                        state_q    <= S_ACK3;
                    end else begin
                        state_q <= S_ACK2;
                    end
                end

                S_ACK3: begin
                    if (rise_s) begin
                        data_oe_q  <= 1'b0;
                        freezing_q <= 1'b0;
                        state_q    <= S_IDLE;
                        if (aeoi && !spurious_q) begin
                            aeoi_clr_q <= onehot8(idx_q);
                        end else begin
                            aeoi_clr_q <= 8'h00;
                        end
                    end else begin
                        state_q <= S_ACK3;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    freezing_q <= 1'b0;
                    data_oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign INT            = int_q;
    assign INT_requestAck = ack_q;
    assign freezing       = freezing_q;
    assign isr_set        = isr_set_q;
    assign aeoi_clr       = aeoi_clr_q;
    assign data_out       = data_out_q;
    assign data_oe        = data_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for interrupt_ack_sequencer. Expected data bytes are
// pushed to a scoreboard queue when a sequence is set up. Each INTA pulse
// that should drive the bus pops one byte and compares it with data_out.
// -----------------------------------------------------------------------------
module tb_interrupt_ack_sequencer;

    logic       clk;
    logic       rst_n;
    logic       INT_request;
    logic [2:0] serviced_interrupt_index;
    logic       INTA_n;
    logic       mode_8086;
    logic       aeoi;
    logic [7:0] icw2;
    logic [2:0] icw1_addr;
    logic       adi;
    logic       INT;
    logic       INT_requestAck;
    logic       freezing;
    logic [7:0] isr_set;
    logic [7:0] aeoi_clr;
    logic [7:0] data_out;
    logic       data_oe;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    interrupt_ack_sequencer dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .INT_request              (INT_request),
        .serviced_interrupt_index (serviced_interrupt_index),
        .INTA_n                   (INTA_n),
        .mode_8086                (mode_8086),
        .aeoi                     (aeoi),
        .icw2                     (icw2),
        .icw1_addr                (icw1_addr),
        .adi                      (adi),
        .INT                      (INT),
        .INT_requestAck           (INT_requestAck),
        .freezing                 (freezing),
        .isr_set                  (isr_set),
        .aeoi_clr                 (aeoi_clr),
        .data_out                 (data_out),
        .data_oe                  (data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encodings, written independently from the RTL.
    function automatic logic [7:0] ref_vec(input logic [7:0] b, input logic [2:0] i);
        logic [7:0] r;
        r = b & 8'hF8;
        r = r | {5'b00000, i};
        return r;
    endfunction

    function automatic logic [7:0] ref_call(input logic [2:0] a, input logic [2:0] i, input logic ad);
        logic [7:0] r;
        if (ad) r = ({5'b00000, a} << 5) | ({5'b00000, i} << 2);
        else    r = ({5'b00000, a} << 5) & 8'hC0 | ({5'b00000, i} << 3);
        return r;
    endfunction

    // A full INTA pulse: two clocks low, then two clocks high.
    // When drive is set, one scoreboard byte is popped and compared.
    // The task returns isr_set at the fall, freezing after the rise and
    // aeoi_clr at the rise.
    task automatic inta_pulse(input string tag, input bit drive,
                              output logic [7:0] isr_f, output logic frz_r,
                              output logic [7:0] clr_r);
        logic [7:0] e;
        INTA_n = 1'b0;
        tick();
        isr_f = isr_set;
        chk({tag, "_oe_fall"}, {7'd0, data_oe}, {7'd0, drive});
        if (drive) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 8'd0, 8'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_data"}, data_out, e);
            end
        end
        tick();
        chk({tag, "_isr_width"}, isr_set, 8'h00);
        INTA_n = 1'b1;
        tick();
        frz_r = freezing;
        clr_r = aeoi_clr;
        chk({tag, "_oe_rise"}, {7'd0, data_oe}, 8'd0);
        tick();
        chk({tag, "_clr_width"}, aeoi_clr, 8'h00);
    endtask

    initial begin
        logic [7:0] isr_f;
        logic [7:0] clr_r;
        logic       frz_r;
        logic       ack0;

        rst_n = 1'b0; INT_request = 1'b1; serviced_interrupt_index = 3'd3;
        INTA_n = 1'b1; mode_8086 = 1'b1; aeoi = 1'b0; icw2 = 8'h40;
        icw1_addr = 3'b101; adi = 1'b1;

        // Reset held with INTA toggling: every output stays 0.
        for (int i = 0; i < 6; i++) begin
            INTA_n = ~INTA_n;
            tick();
            chk("rst_outs", {INT, INT_requestAck, freezing, data_oe, 4'd0}, 8'h00);
            chk("rst_isr_clr", isr_set | aeoi_clr, 8'h00);
            chk("rst_data", data_out, 8'h00);
        end
        INTA_n = 1'b1; INT_request = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        INT_request = 1'b1; serviced_interrupt_index = 3'd3;
        chk("int_lag_before", {7'd0, INT}, 8'd0);
        tick();
        chk("int_lag_after", {7'd0, INT}, 8'd1);
        INT_request = 1'b0;
        tick();
        chk("int_drop", {7'd0, INT}, 8'd0);

        // 8086 mode, no AEOI, IR5.
        mode_8086 = 1'b1; aeoi = 1'b0; icw2 = 8'h40;
        INT_request = 1'b1; serviced_interrupt_index = 3'd5;
        tick();
        ack0 = INT_requestAck;
        exp_q.push_back(ref_vec(icw2, 3'd5));
        inta_pulse("m86_p1", 1'b0, isr_f, frz_r, clr_r);
        chk("m86_isr", isr_f, 8'h20);
        chk("m86_frz_mid", {7'd0, frz_r}, 8'd1);
        chk("m86_ack", {7'd0, INT_requestAck}, {7'd0, ~ack0});
        chk("m86_int_low", {7'd0, INT}, 8'd0);
        inta_pulse("m86_p2", 1'b1, isr_f, frz_r, clr_r);
        chk("m86_frz_end", {7'd0, frz_r}, 8'd0);
        chk("m86_noclr", clr_r, 8'h00);
        chk("m86_ack_once", {7'd0, INT_requestAck}, {7'd0, ~ack0});

        // 8080 mode, interval 4, IR2.
        mode_8086 = 1'b0; icw1_addr = 3'b101; icw2 = 8'h12; adi = 1'b1;
        serviced_interrupt_index = 3'd2;
        tick();
        exp_q.push_back(8'hCD);
        exp_q.push_back(ref_call(icw1_addr, 3'd2, 1'b1));
        exp_q.push_back(8'h12);
        inta_pulse("m80a_p1", 1'b1, isr_f, frz_r, clr_r);
        chk("m80a_isr", isr_f, 8'h04);
        inta_pulse("m80a_p2", 1'b1, isr_f, frz_r, clr_r);
        chk("m80a_frz_mid", {7'd0, frz_r}, 8'd1);
        inta_pulse("m80a_p3", 1'b1, isr_f, frz_r, clr_r);
        chk("m80a_frz_end", {7'd0, frz_r}, 8'd0);

        // 8080 mode, interval 8.
        adi = 1'b0;
        tick();
        exp_q.push_back(8'hCD);
        exp_q.push_back(ref_call(icw1_addr, 3'd2, 1'b0));
        exp_q.push_back(8'h12);
        inta_pulse("m80b_p1", 1'b1, isr_f, frz_r, clr_r);
        inta_pulse("m80b_p2", 1'b1, isr_f, frz_r, clr_r);
        inta_pulse("m80b_p3", 1'b1, isr_f, frz_r, clr_r);
        chk("m80_sb_drained", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);

        // 8086 with AEOI, IR0. The resolver changes mid-sequence.
        mode_8086 = 1'b1; aeoi = 1'b1; icw2 = 8'h88;
        serviced_interrupt_index = 3'd0;
        tick();
        exp_q.push_back(ref_vec(8'h88, 3'd0));
        inta_pulse("aeoi_p1", 1'b0, isr_f, frz_r, clr_r);
        chk("aeoi_isr", isr_f, 8'h01);
        serviced_interrupt_index = 3'd6;
        tick();
        chk("aeoi_int_held", {7'd0, INT}, 8'd0);
        inta_pulse("aeoi_p2", 1'b1, isr_f, frz_r, clr_r);
        chk("aeoi_clr", clr_r, 8'h01);

        // Spurious: the request drops before INTA.
        INT_request = 1'b1; serviced_interrupt_index = 3'd4;
        tick();
        INT_request = 1'b0;
        tick();
        ack0 = INT_requestAck;
        exp_q.push_back(ref_vec(8'h88, 3'd7));
        inta_pulse("spur_p1", 1'b0, isr_f, frz_r, clr_r);
        chk("spur_isr", isr_f, 8'h00);
        inta_pulse("spur_p2", 1'b1, isr_f, frz_r, clr_r);
        chk("spur_clr", clr_r, 8'h00);
        chk("spur_ack", {7'd0, INT_requestAck}, {7'd0, ack0});

        // Reset while in ACK2 (8080 mode, AEOI on).
        mode_8086 = 1'b0; adi = 1'b1; INT_request = 1'b1;
        serviced_interrupt_index = 3'd1;
        tick();
        exp_q.push_back(8'hCD);
        inta_pulse("rmid_p1", 1'b1, isr_f, frz_r, clr_r);
        INTA_n = 1'b0;
        tick();
        chk("rmid_oe_ack2", {7'd0, data_oe}, 8'd1);
        chk("rmid_byte2", data_out, ref_call(3'b101, 3'd1, 1'b1));
        rst_n = 1'b0;
        tick();
        chk("rmid_frz", {7'd0, freezing}, 8'd0);
        chk("rmid_oe", {7'd0, data_oe}, 8'd0);
        chk("rmid_clr", aeoi_clr, 8'h00);
        rst_n = 1'b1; INTA_n = 1'b1;
        tick();
        chk("rmid_clr_after", aeoi_clr, 8'h00);
        tick();
        chk("rmid_idle_int", {7'd0, INT}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
